prefetch_queue: RTL and testbench

- Instruction prefetch unit directly upstream of the core's decode/execute pipeline.
- Owns the ROM fetch port and fetches code bytes at physical address CS*16+IP into a 6-entry byte FIFO.
- Presents one byte per cycle to the decoder via a valid/ready handshake.
- On a control-transfer redirect, discards all queued and in-flight bytes and restarts fetch at the new CS:IP.

---
 rtl/prefetch_queue.sv | 118 +++++++++++
 tb/tb_prefetch_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// prefetch_queue
//   Instruction prefetch unit sitting directly in front of the decoder.
//   It fetches code bytes from the synchronous ROM at CS*16+IP into a DEPTH-entry
//   byte FIFO and hands them to the decoder one byte per cycle.
//   A flush (redirect) discards every queued and in-flight byte and restarts
//   fetching at the new CS:IP.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active low
//   rom_en    ROM read strobe (one byte request per cycle while high)
//   rom_addr  20-bit physical fetch address
//   rom_data  ROM read data, valid one cycle after rom_en
//   flush     redirect request; overrides all other activity this cycle
//   flush_cs  new code segment (sampled while flush=1)
//   flush_ip  new instruction pointer (sampled while flush=1)
//   q_ready   decoder takes the head byte this cycle
//   q_valid   head byte present
//   q_byte    head byte (zero when empty)
//   q_ip      IP of the head byte (zero when empty)
//   q_count   number of bytes currently held
module prefetch_queue #(
  parameter int          DEPTH    = 6,
  parameter logic [15:0] RESET_CS = 16'h0000,
  parameter logic [15:0] RESET_IP = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_en,
  output logic [19:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        flush,
  input  logic [15:0] flush_cs,
  input  logic [15:0] flush_ip,
  input  logic        q_ready,
  output logic        q_valid,
  output logic [7:0]  q_byte,
  output logic [15:0] q_ip,
  output logic [2:0]  q_count
);

  localparam logic [2:0] LAST_PTR = 3'(DEPTH - 1);
  localparam logic [3:0] DEPTH_W  = 4'(DEPTH);

  logic [7:0]  mem_byte [DEPTH];
  logic [15:0] mem_ip   [DEPTH];

  logic [2:0]  rd_ptr;
  logic [2:0]  wr_ptr;
  logic [2:0]  count;
  logic        inflight;
  logic [15:0] req_ip;
  logic [15:0] fetch_cs;
  logic [15:0] fetch_ip;

  logic        push;
  logic        pop;

  function automatic logic [2:0] next_ptr(input logic [2:0] p);
    return (p == LAST_PTR) ? 3'd0 : p + 3'd1;
  endfunction

  // Free-space test ignores a same-cycle pop; gated by rst so the strobe is
  // low throughout reset even though the counters already read as empty.
  assign rom_en   = rst & ~flush & (({1'b0, count} + {3'b000, inflight}) < DEPTH_W);
  // 20-bit sum naturally wraps FFFF:0010 to 0x00000.
  assign rom_addr = {fetch_cs, 4'h0} + {4'h0, fetch_ip};

  assign q_valid  = (count != 3'd0);
  assign q_count  = count;
  assign q_byte   = q_valid ? mem_byte[rd_ptr] : 8'h00;
  assign q_ip     = q_valid ? mem_ip[rd_ptr]   : 16'h0000;

  // A returning byte during a flush belongs to the old target and is dropped.
  assign push = inflight & ~flush;
  assign pop  = q_valid & q_ready & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= 3'd0;
      wr_ptr   <= 3'd0;
      count    <= 3'd0;
      inflight <= 1'b0;
      req_ip   <= 16'h0000;
      fetch_cs <= RESET_CS;
      fetch_ip <= RESET_IP;
    end else if (flush) begin
      rd_ptr   <= 3'd0;
      wr_ptr   <= 3'd0;
      count    <= 3'd0;
      inflight <= 1'b0;
      fetch_cs <= flush_cs;
      fetch_ip <= flush_ip;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      inflight <= rom_en;
      if (rom_en) begin
        req_ip   <= fetch_ip;
        fetch_ip <= fetch_ip + 16'd1;
      end
    end
  end

  // Payload storage needs no reset: q_byte/q_ip are masked while count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_byte[wr_ptr] <= rom_data;
      mem_ip[wr_ptr]   <= req_ip;
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
module tb_prefetch_queue;

  localparam int DEPTH = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_en;
  logic [19:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic        flush;
  logic [15:0] flush_cs;
  logic [15:0] flush_ip;
  logic        q_ready;
  logic        q_valid;
  logic [7:0]  q_byte;
  logic [15:0] q_ip;
  logic [2:0]  q_count;

  prefetch_queue #(.DEPTH(DEPTH), .RESET_CS(16'h0000), .RESET_IP(16'h0000)) dut (
    .clk(clk), .rst(rst), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .flush(flush), .flush_cs(flush_cs), .flush_ip(flush_ip), .q_ready(q_ready),
    .q_valid(q_valid), .q_byte(q_byte), .q_ip(q_ip), .q_count(q_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'hA5;
  endfunction

  function automatic logic [19:0] phys(input logic [15:0] cs, input logic [15:0] ip);
    int unsigned s;
    s = (int'(cs) * 16 + int'(ip)) % (1 << 20);
    return s[19:0];
  endfunction

  // Synchronous ROM, one cycle latency.
  always @(posedge clk) if (rom_en) rom_data <= rom_fn(rom_addr);

  typedef struct packed {
    logic [7:0]  b;
    logic [15:0] ip;
  } ent_t;

  // Reference model: the bytes the decoder should see, plus one outstanding request.
  ent_t        mq[$];
  bit          pend;
  logic [19:0] pend_addr;
  logic [15:0] pend_ip;
  logic [15:0] m_cs;
  logic [15:0] m_ip;
  bit          m_en;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    pend = 0;
    m_cs = 16'h0000;
    m_ip = 16'h0000;
  endtask

  task automatic check_model();
    ent_t h;
    m_en = rst && !flush && ((mq.size() + int'(pend)) < DEPTH);
    h = (mq.size() > 0) ? mq[0] : '0;
    chk("rom_en",   {31'b0, rom_en},   {31'b0, m_en});
    chk("rom_addr", {12'b0, rom_addr}, {12'b0, phys(m_cs, m_ip)});
    chk("q_valid",  {31'b0, q_valid},  {31'b0, mq.size() > 0});
    chk("q_count",  {29'b0, q_count},  32'(mq.size()));
    chk("q_byte",   {24'b0, q_byte},   {24'b0, h.b});
    chk("q_ip",     {16'b0, q_ip},     {16'b0, h.ip});
  endtask

  task automatic update_model();
    ent_t e;
    if (flush) begin
      mq.delete();
      pend = 0;
      m_cs = flush_cs;
      m_ip = flush_ip;
    end else begin
      if (mq.size() > 0 && q_ready) void'(mq.pop_front());
      if (pend) begin
        e.b  = rom_fn(pend_addr);
        e.ip = pend_ip;
        mq.push_back(e);
      end
      pend = m_en;
      if (m_en) begin
        pend_addr = phys(m_cs, m_ip);
        pend_ip   = m_ip;
        m_ip      = m_ip + 16'd1;
      end
    end
  endtask

  // One clock: drive inputs, compare at the falling edge, advance model at the rising edge.
  task automatic step(input bit f, input logic [15:0] fcs, input logic [15:0] fip, input bit rdy);
    flush    = f;
    flush_cs = fcs;
    flush_ip = fip;
    q_ready  = rdy;
    @(negedge clk);
    check_model();
    @(posedge clk);
    update_model();
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; flush_cs = '0; flush_ip = '0; q_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rom_en",  {31'b0, rom_en},  32'd0);
    chk("rst_q_valid", {31'b0, q_valid}, 32'd0);
    chk("rst_q_count", {29'b0, q_count}, 32'd0);
    chk("rst_rom_addr", {12'b0, rom_addr}, 32'd0);
    rst = 1'b1;

    // Streaming from reset with the decoder always ready.
    repeat (12) step(0, '0, '0, 1);

    // Decoder stalls: queue fills, fetch stops; one pop lets exactly one fetch through.
    repeat (10) step(0, '0, '0, 0);
    chk("full_count", {29'b0, q_count}, 32'd6);
    chk("full_rom_en", {31'b0, rom_en}, 32'd0);
    step(0, '0, '0, 1);
    repeat (4) step(0, '0, '0, 0);

    // Flush with 4 queued and 1 in flight.
    step(1, 16'h2000, 16'h0100, 0);
    repeat (5) step(0, '0, '0, 0);
    chk("pre_flush_count", {29'b0, q_count}, 32'd4);
    step(1, 16'h1000, 16'h0020, 0);
    chk("post_flush_count", {29'b0, q_count}, 32'd0);
    chk("post_flush_addr", {12'b0, rom_addr}, 32'h10020);
    repeat (8) step(0, '0, '0, 1);

    // IP wraps inside the segment.
    step(1, 16'h0000, 16'hFFFE, 1);
    repeat (6) step(0, '0, '0, 1);

    // Physical address wraps at 2^20.
    step(1, 16'hFFFF, 16'h000F, 1);
    chk("wrap_addr", {12'b0, rom_addr}, 32'hFFFFF);
    repeat (5) step(0, '0, '0, 1);

    // Back-to-back flushes: only the last target is fetched.
    step(1, 16'h1234, 16'h0000, 1);
    step(1, 16'h4321, 16'h0000, 1);
    step(1, 16'h0ABC, 16'h0010, 1);
    repeat (8) step(0, '0, '0, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 24) == 0, 16'($urandom), 16'($urandom), $urandom_range(0, 3) != 0);
    end

    // Reset with 3 bytes queued and one request in flight.
    step(1, 16'h0500, 16'h0000, 0);
    repeat (4) step(0, '0, '0, 0);
    chk("pre_rst_count", {29'b0, q_count}, 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("arst_rom_en",  {31'b0, rom_en},  32'd0);
    chk("arst_q_valid", {31'b0, q_valid}, 32'd0);
    chk("arst_q_byte",  {24'b0, q_byte},  32'd0);
    chk("arst_q_ip",    {16'b0, q_ip},    32'd0);
    chk("arst_q_count", {29'b0, q_count}, 32'd0);
    chk("arst_rom_addr", {12'b0, rom_addr}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) step(0, '0, '0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
